// File: rtl/teclado_ps2.sv
// PS/2 keyboard receiver for the piano display: filters the PS/2 lines, frames bytes,
// tracks make/break prefixes and holds the 6-bit note code of the last key pressed.
module teclado_ps2 #(
    parameter int FILTRO  = 8,
    parameter int TIMEOUT = 50000,
    parameter int W_TO    = 16
) (
    input  logic       clk50mhz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [5:0] tecla,
    output logic       tecla_nueva,
    output logic       err_trama
);
    localparam int W_F = $clog2(FILTRO + 1);
    localparam logic [W_F-1:0]  FILT_MAX = W_F'(FILTRO - 1);
    localparam logic [W_TO-1:0] TO_MAX   = W_TO'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARIDAD, STOP} estado_t;

    logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic           r_clk_f, r_bajada;
    logic [W_F-1:0] r_filt_cnt;
    estado_t        r_estado;
    logic [7:0]     r_shift, r_byte;
    logic [2:0]     r_bitcnt;
    logic           r_par, r_byte_ok, r_err;
    logic [W_TO-1:0] r_to_cnt;
    logic           r_ext, r_solt, r_nueva;
    logic [5:0]     r_tecla;
    logic [5:0]     w_nota;

    function automatic logic [5:0] f_mapa(input logic [7:0] code);
        case (code)
            8'h1C:   return 6'd1;
            8'h1D:   return 6'd2;
            8'h1B:   return 6'd3;
            8'h24:   return 6'd4;
            8'h23:   return 6'd5;
            8'h2B:   return 6'd6;
            8'h2C:   return 6'd7;
            8'h34:   return 6'd8;
            8'h35:   return 6'd9;
            8'h33:   return 6'd10;
            8'h3C:   return 6'd11;
            8'h3B:   return 6'd12;
            8'h42:   return 6'd13;
            default: return 6'd0;
        endcase
    endfunction

    assign w_nota = f_mapa(r_byte);

    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_f    <= 1'b1;
            r_bajada   <= 1'b0;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_bajada <= 1'b0;
            // Any return to the accepted level restarts the stability count.
            if (r_clk_s2 != r_clk_f) begin
                if (r_filt_cnt == FILT_MAX) begin
                    r_clk_f    <= r_clk_s2;
                    r_bajada   <= ~r_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            r_estado  <= IDLE;
            r_shift   <= '0;
            r_byte    <= '0;
            r_bitcnt  <= '0;
            r_par     <= 1'b0;
            r_byte_ok <= 1'b0;
            r_err     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_byte_ok <= 1'b0;
            r_err     <= 1'b0;
            // Timeout takes priority over a bajada arriving in the same cycle.
            if (r_estado != IDLE && r_to_cnt == TO_MAX) begin
                r_estado <= IDLE;
                r_err    <= 1'b1;
                r_to_cnt <= '0;
            end else begin
                if (r_estado == IDLE || r_bajada)
                    r_to_cnt <= '0;
                else
                    r_to_cnt <= r_to_cnt + 1'b1;
                if (r_bajada) begin
                    case (r_estado)
                        IDLE: begin
                            if (!r_dat_s2) begin
                                r_estado <= DATA;
                                r_bitcnt <= '0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        DATA: begin
                            r_shift  <= {r_dat_s2, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7)
                                r_estado <= PARIDAD;
                        end
                        PARIDAD: begin
                            r_par    <= r_dat_s2;
                            r_estado <= STOP;
                        end
                        STOP: begin
                            if (r_dat_s2 && (^{r_shift, r_par})) begin
                                r_byte    <= r_shift;
                                r_byte_ok <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                            r_estado <= IDLE;
                        end
                        default: r_estado <= IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            r_ext   <= 1'b0;
            r_solt  <= 1'b0;
            r_tecla <= '0;
            r_nueva <= 1'b0;
        end else begin
            r_nueva <= 1'b0;
            if (r_byte_ok) begin
                if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_solt <= 1'b1;
                end else begin
                    r_ext  <= 1'b0;
                    r_solt <= 1'b0;
                    // Extended codes never map to notes; a break only releases the held note.
                    if (!r_ext && w_nota != 6'd0) begin
                        if (!r_solt) begin
                            if (w_nota != r_tecla) begin
                                r_tecla <= w_nota;
                                r_nueva <= 1'b1;
                            end
                        end else if (w_nota == r_tecla) begin
                            r_tecla <= 6'd0;
                            r_nueva <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign tecla       = r_tecla;
    assign tecla_nueva = r_nueva;
    assign err_trama   = r_err;
endmodule

// File: tb/tb_teclado_ps2.sv
// Directed bench for teclado_ps2: stimulus pushes expected events (note value or -1 for a
// frame error) into a queue; a monitor pops and compares on every tecla_nueva/err_trama pulse.
module tb_teclado_ps2;
    localparam int HALF = 20;

    logic       clk50mhz = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [5:0] tecla;
    logic       tecla_nueva;
    logic       err_trama;

    int n_checks = 0;
    int n_fail   = 0;
    int q_exp[$];

    always #10 clk50mhz = ~clk50mhz;

    teclado_ps2 #(.FILTRO(8), .TIMEOUT(50000), .W_TO(16)) dut (
        .clk50mhz    (clk50mhz),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .tecla       (tecla),
        .tecla_nueva (tecla_nueva),
        .err_trama   (err_trama)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk50mhz);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~^b;
        if (bad_par) p = ~p;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Each bit: data set while clock high, then clock falls; optional sub-FILTRO glitches.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                idle(5); ps2_clk = 1'b0; idle(1); ps2_clk = 1'b1; idle(HALF - 6);
            end else idle(HALF);
            ps2_clk = 1'b0;
            if (glitch) begin
                idle(5); ps2_clk = 1'b1; idle(1); ps2_clk = 1'b0; idle(HALF - 6);
            end else idle(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit glitch);
        send_bits(frame(b, bad_par), 11, glitch);
        idle(3 * HALF);
    endtask

    initial begin
        forever begin
            @(negedge clk50mhz);
            if (err_trama) begin
                if (q_exp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_err_trama: got pulse, expected none");
                end else check("err_trama_event", -1, q_exp.pop_front());
            end
            if (tecla_nueva) begin
                if (q_exp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_tecla_nueva: got pulse with tecla=%0d, expected none", tecla);
                end else check("tecla_nueva_value", int'(tecla), q_exp.pop_front());
            end
        end
    end

    initial begin
        int cyc;
        int seen;
        idle(3);
        check("reset_tecla", int'(tecla), 0);
        check("reset_tecla_nueva", int'(tecla_nueva), 0);
        check("reset_err_trama", int'(err_trama), 0);
        reset = 1'b1;
        idle(20);

        // Single make
        q_exp.push_back(1);
        send(8'h1C, 1'b0, 1'b0);
        check("t1_tecla", int'(tecla), 1);

        // Last pressed wins, break of a non-held key ignored, break of held key releases
        q_exp.push_back(5);
        send(8'h23, 1'b0, 1'b0);
        check("t2_make23", int'(tecla), 5);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        check("t2_break1C_ignored", int'(tecla), 5);
        q_exp.push_back(0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h23, 1'b0, 1'b0);
        check("t2_break23", int'(tecla), 0);

        // Parity error, then recovery
        q_exp.push_back(-1);
        send(8'h1C, 1'b1, 1'b0);
        check("t3_parity_tecla", int'(tecla), 0);
        q_exp.push_back(3);
        send(8'h1B, 1'b0, 1'b0);
        check("t3_tecla", int'(tecla), 3);

        // Partial frame then 1.2 ms of silence
        q_exp.push_back(-1);
        send_bits(frame(8'h24, 1'b0), 5, 1'b0);
        cyc  = HALF;
        seen = -1;
        while (cyc < 60000) begin
            @(negedge clk50mhz);
            cyc++;
            if (err_trama && seen < 0) seen = cyc;
        end
        n_checks++;
        if (seen < 50005 || seen > 50030) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles, expected 50005..50030", seen);
        end
        check("t4_tecla_kept", int'(tecla), 3);
        q_exp.push_back(4);
        send(8'h24, 1'b0, 1'b0);
        check("t4_tecla", int'(tecla), 4);

        // Extended prefix suppresses the note; typematic repeats are silent
        send(8'hE0, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        check("t5_ext_ignored", int'(tecla), 4);
        q_exp.push_back(1);
        send(8'h1C, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        check("t5_tecla", int'(tecla), 1);

        // Reset mid-frame, then a glitchy but valid frame
        send_bits(frame(8'h42, 1'b0), 6, 1'b0);
        reset = 1'b0;
        idle(5);
        check("t6_reset_tecla", int'(tecla), 0);
        check("t6_reset_err", int'(err_trama), 0);
        idle(5);
        reset = 1'b1;
        idle(20);
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0; idle(1); ps2_clk = 1'b1; idle(10);
        end
        idle(HALF);
        check("t6_after_glitch_tecla", int'(tecla), 0);
        q_exp.push_back(13);
        send(8'h42, 1'b0, 1'b1);
        check("t6_tecla", int'(tecla), 13);

        idle(100);
        check("queue_drained", q_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
